// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg -- shared definitions for the traffic_light_ctrl_n controller.
//   LIGHT_*  : two-bit lamp codes driven per approach on the lights bus.
//   phase_e  : controller phase, also the encoding of the phase output.
// ---------------------------------------------------------------------------
package tl_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_YELLOW  = 2'b01,
        PH_GREEN   = 2'b10
    } phase_e;

endpackage : tl_pkg

// File: rtl/tl_next_dir.sv
// ---------------------------------------------------------------------------
// tl_next_dir -- combinational round-robin demand search.
//   Looks at cur_dir+1, cur_dir+2, ... (mod NUM_DIR) and returns the first
//   approach with demand, never cur_dir itself.
// Ports:
//   cur_dir  in  DIR_W    approach currently served
//   demand   in  NUM_DIR  per-approach vehicle-present flags
//   cand     out DIR_W    first approach with demand after cur_dir
//   found    out 1        cand is valid (some other approach has demand)
// ---------------------------------------------------------------------------
module tl_next_dir
    import tl_pkg::*;
#(
    parameter int NUM_DIR = 4,
    parameter int DIR_W   = $clog2(NUM_DIR)
) (
    input  logic [DIR_W-1:0]   cur_dir,
    input  logic [NUM_DIR-1:0] demand,
    output logic [DIR_W-1:0]   cand,
    output logic               found
);

    always_comb begin
        // NOTE: combinational blocks use blocking assignments, and every
        // output gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        int idx;
        idx   = 0;
        cand  = '0;
        found = 1'b0;
        // Offsets start at 1 and stop before NUM_DIR, so cur_dir is excluded.
        for (int k = 1; k < NUM_DIR; k++) begin
            idx = int'(cur_dir) + k;
            if (idx >= NUM_DIR) begin
                idx = idx - NUM_DIR;
            end
            if (!found && demand[idx[DIR_W-1:0]]) begin
                cand  = idx[DIR_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule : tl_next_dir

// File: rtl/traffic_light_ctrl_n.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl_n -- N-approach traffic light sequencer.
//   Cycles GREEN -> YELLOW -> ALL_RED per approach with programmable
//   durations (in prescaler ticks) and optional demand-driven skipping.
//   At most one approach is ever non-red.
// Optional feature: define TL_PREEMPT_EN to add emergency preemption
//   (preempt_req / preempt_dir ports).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   green_len       green duration in ticks (0 behaves as 1)
//   yellow_len      yellow duration in ticks (0 behaves as 1)
//   allred_len      all-red clearance in ticks (0 behaves as 1)
//   skip_en         1 = skip approaches without demand
//   demand          per-approach vehicle-present flags (level)
//   lights          approach i on [2i+1:2i]: 00 red, 01 yellow, 10 green
//   cur_dir         approach currently served
//   phase           00 ALL_RED, 01 YELLOW, 10 GREEN
//   tick            one-cycle prescaler pulse
//   preempt_req     (TL_PREEMPT_EN) preemption request, level
//   preempt_dir     (TL_PREEMPT_EN) approach to preempt to
// ---------------------------------------------------------------------------
module traffic_light_ctrl_n
    import tl_pkg::*;
#(
    parameter int NUM_DIR  = 4,
    parameter int PRESCALE = 1000,
    parameter int CNT_W    = 8,
    parameter int DIR_W    = $clog2(NUM_DIR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CNT_W-1:0]       green_len,
    input  logic [CNT_W-1:0]       yellow_len,
    input  logic [CNT_W-1:0]       allred_len,
    input  logic                   skip_en,
    input  logic [NUM_DIR-1:0]     demand,
    output logic [2*NUM_DIR-1:0]   lights,
    output logic [DIR_W-1:0]       cur_dir,
    output logic [1:0]             phase,
    output logic                   tick
`ifdef TL_PREEMPT_EN
    ,
    input  logic                   preempt_req,
    input  logic [DIR_W-1:0]       preempt_dir
`endif
);

    localparam int                PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [DIR_W-1:0]  DIR_LAST = DIR_W'(NUM_DIR - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // A programmed length of zero would never reach the expiry value of 1.
    function automatic logic [CNT_W-1:0] entry_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_ONE : len;
    endfunction

    phase_e                 phase_q, phase_d;
    logic [DIR_W-1:0]       cur_dir_q, cur_dir_d;
    logic [DIR_W-1:0]       next_dir_q, next_dir_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic [2*NUM_DIR-1:0]   lights_q, lights_d;
    logic [PS_W-1:0]        presc_q, presc_d;
    logic                   tick_q, tick_d;

    logic                   expire;
    logic [DIR_W-1:0]       rr_next;
    logic [DIR_W-1:0]       cand;
    logic                   found;

    // Preemption hooks; tied off when the feature is compiled out so the
    // state machine below is identical in both builds.
    logic                   preempt_hold;
    logic                   preempt_go;
    logic                   ovr_valid;
    logic [DIR_W-1:0]       ovr_dir;

`ifdef TL_PREEMPT_EN
    logic preempt_q, preempt_d;

    assign preempt_d    = preempt_req;
    assign preempt_hold = preempt_req && (preempt_dir == cur_dir_q);
    assign preempt_go   = preempt_req && !preempt_q && (preempt_dir != cur_dir_q);
    assign ovr_valid    = preempt_req;
    assign ovr_dir      = preempt_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= preempt_d;
        end
    end
`else
    assign preempt_hold = 1'b0;
    assign preempt_go   = 1'b0;
    assign ovr_valid    = 1'b0;
    assign ovr_dir      = '0;
`endif

    tl_next_dir #(
        .NUM_DIR (NUM_DIR),
        .DIR_W   (DIR_W)
    ) u_next_dir (
        .cur_dir (cur_dir_q),
        .demand  (demand),
        .cand    (cand),
        .found   (found)
    );

    // Prescaler: tick_q is high exactly while presc_q sits at PRESCALE-1.
    assign presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
    assign tick_d  = (presc_d == PS_LAST);

    // Explicit wrap keeps non-power-of-two NUM_DIR correct.
    assign rr_next = (cur_dir_q == DIR_LAST) ? '0 : cur_dir_q + 1'b1;
    assign expire  = tick_q && (timer_q == CNT_ONE);

    always_comb begin
        phase_d    = phase_q;
        cur_dir_d  = cur_dir_q;
        next_dir_d = next_dir_q;
        timer_d    = timer_q;
        lights_d   = '0;

        if (tick_q) begin
            timer_d = timer_q - 1'b1;
        end

        case (phase_q)
            PH_ALL_RED: begin
                if (ovr_valid) begin
                    next_dir_d = ovr_dir;
                end
                if (expire) begin
                    phase_d   = PH_GREEN;
                    cur_dir_d = ovr_valid ? ovr_dir : next_dir_q;
                    timer_d   = entry_len(green_len);
                end
            end
            PH_GREEN: begin
                if (preempt_hold) begin
                    timer_d = timer_q;
                end else if (preempt_go) begin
                    phase_d    = PH_YELLOW;
                    next_dir_d = ovr_dir;
                    timer_d    = entry_len(yellow_len);
                end else if (expire) begin
                    if (!skip_en) begin
                        phase_d    = PH_YELLOW;
                        next_dir_d = rr_next;
                        timer_d    = entry_len(yellow_len);
                    end else if (found) begin
                        phase_d    = PH_YELLOW;
                        next_dir_d = cand;
                        timer_d    = entry_len(yellow_len);
                    end else begin
                        // Nobody else waiting: extend this green.
                        timer_d = entry_len(green_len);
                    end
                end
            end
            PH_YELLOW: begin
                if (ovr_valid) begin
                    next_dir_d = ovr_dir;
                end
                if (expire) begin
                    phase_d = PH_ALL_RED;
                    timer_d = entry_len(allred_len);
                end
            end
            default: begin
                phase_d = PH_ALL_RED;
                timer_d = CNT_ONE;
            end
        endcase

        // Lamps are decoded from the next state so they register together
        // with phase and cur_dir.
        for (int i = 0; i < NUM_DIR; i++) begin
            if (cur_dir_d == DIR_W'(i)) begin
                if (phase_d == PH_GREEN) begin
                    lights_d[2*i +: 2] = LIGHT_GREEN;
                end else if (phase_d == PH_YELLOW) begin
                    lights_d[2*i +: 2] = LIGHT_YELLOW;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples the pre-edge values of the others.
        if (!rst_n) begin
            phase_q    <= PH_ALL_RED;
            cur_dir_q  <= '0;
            next_dir_q <= '0;
            timer_q    <= CNT_ONE;
            lights_q   <= '0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            cur_dir_q  <= cur_dir_d;
            next_dir_q <= next_dir_d;
            timer_q    <= timer_d;
            lights_q   <= lights_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
        end
    end

    assign lights  = lights_q;
    assign cur_dir = cur_dir_q;
    assign phase   = phase_q;
    assign tick    = tick_q;

endmodule : traffic_light_ctrl_n

// File: tb/tb_traffic_light_ctrl_n.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_ctrl_n -- self-checking bench for traffic_light_ctrl_n.
//   dut4: NUM_DIR=4, PRESCALE=4.  dut3: NUM_DIR=3, PRESCALE=4 (wrap check).
//   Expected phase transitions (phase, approach, cycles since previous
//   transition) are queued by the stimulus and matched against transitions
//   recorded by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_traffic_light_ctrl_n;

    localparam logic [1:0] AR = 2'b00;
    localparam logic [1:0] YL = 2'b01;
    localparam logic [1:0] GR = 2'b10;

    typedef struct {
        logic [1:0] ph;
        logic [1:0] dir;
        int         dur;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  green_len, yellow_len, allred_len;
    logic        skip_en;
    logic [3:0]  demand;
    logic [7:0]  lights;
    logic [1:0]  cur_dir;
    logic [1:0]  phase;
    logic        tick;

    logic [7:0]  g3, y3, a3;
    logic        skip3;
    logic [2:0]  demand3;
    logic [5:0]  lights3;
    logic [1:0]  cur_dir3;
    logic [1:0]  phase3;
    logic        tick3;

    logic        preempt_req;
    logic [1:0]  preempt_dir;
    logic        preempt_req3;
    logic [1:0]  preempt_dir3;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    ev_t sb[$];
    ev_t sb3[$];

    logic [1:0] obs_ph  [256];
    logic [1:0] obs_dir [256];
    int         obs_dur [256];
    logic [7:0] obs_lt  [256];
    int         obs_wr  = 0;
    int         obs_rd  = 0;
    int         inv_err = 0;
    logic [1:0] prev_ph;
    logic [1:0] prev_dir;
    int         last_cyc = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl_n #(.NUM_DIR(4), .PRESCALE(4), .CNT_W(8)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .green_len  (green_len),
        .yellow_len (yellow_len),
        .allred_len (allred_len),
        .skip_en    (skip_en),
        .demand     (demand),
        .lights     (lights),
        .cur_dir    (cur_dir),
        .phase      (phase),
        .tick       (tick)
`ifdef TL_PREEMPT_EN
        ,
        .preempt_req (preempt_req),
        .preempt_dir (preempt_dir)
`endif
    );

    traffic_light_ctrl_n #(.NUM_DIR(3), .PRESCALE(4), .CNT_W(8)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .green_len  (g3),
        .yellow_len (y3),
        .allred_len (a3),
        .skip_en    (skip3),
        .demand     (demand3),
        .lights     (lights3),
        .cur_dir    (cur_dir3),
        .phase      (phase3),
        .tick       (tick3)
`ifdef TL_PREEMPT_EN
        ,
        .preempt_req (preempt_req3),
        .preempt_dir (preempt_dir3)
`endif
    );

    // Lamp bus implied by a (phase, approach) pair; the light codes for
    // yellow and green equal the phase codes.
    function automatic logic [31:0] exp_l(input logic [1:0] ph, input logic [1:0] dir);
        logic [31:0] v;
        v = {30'b0, ph};
        if (ph == AR) return 32'b0;
        return v << (2 * int'(dir));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transition recorder and per-cycle lamp consistency monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ph  <= AR;
            prev_dir <= 2'b00;
            last_cyc <= cyc;
        end else begin
            if (phase !== prev_ph || cur_dir !== prev_dir) begin
                obs_ph[obs_wr % 256]  <= phase;
                obs_dir[obs_wr % 256] <= cur_dir;
                obs_dur[obs_wr % 256] <= cyc - last_cyc;
                obs_lt[obs_wr % 256]  <= lights;
                obs_wr   <= obs_wr + 1;
                prev_ph  <= phase;
                prev_dir <= cur_dir;
                last_cyc <= cyc;
            end
            if ({24'b0, lights} !== exp_l(phase, cur_dir)) inv_err <= inv_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic push(input logic [1:0] ph, input logic [1:0] dir, input int dur);
        ev_t e;
        e.ph  = ph;
        e.dir = dir;
        e.dur = dur;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int limit);
        int  n;
        ev_t e;
        n = 0;
        while (sb.size() > 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
            while (obs_rd != obs_wr && sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "/phase"},  32'(obs_ph[obs_rd % 256]),  32'(e.ph));
                check({tag, "/dir"},    32'(obs_dir[obs_rd % 256]), 32'(e.dir));
                check({tag, "/cycles"}, obs_dur[obs_rd % 256],      e.dur);
                check({tag, "/lights"}, 32'(obs_lt[obs_rd % 256]),  exp_l(e.ph, e.dir));
                obs_rd++;
            end
        end
        check({tag, "/pending_after_timeout"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n  = 1'b1;
        obs_rd = obs_wr;
        sb.delete();
    endtask

    task automatic seg_end(input string tag);
        repeat (2) @(negedge clk);
        #1;
        check({tag, "/unexpected_transitions"}, obs_wr - obs_rd, 0);
        check({tag, "/lamp_consistency_errors"}, inv_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ev_t e3;
        int  seg;
        bit  seen;

        green_len    = 8'd5;
        yellow_len   = 8'd2;
        allred_len   = 8'd1;
        skip_en      = 1'b0;
        demand       = 4'b0000;
        g3           = 8'd0;
        y3           = 8'd0;
        a3           = 8'd1;
        skip3        = 1'b0;
        demand3      = 3'b000;
        preempt_req  = 1'b0;
        preempt_dir  = 2'd2;
        preempt_req3 = 1'b0;
        preempt_dir3 = 2'd0;

        // Reset values, applied asynchronously before any clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset/lights",  32'(lights),  32'h0);
        check("reset/phase",   32'(phase),   32'(AR));
        check("reset/cur_dir", 32'(cur_dir), 32'h0);
        check("reset/tick",    32'(tick),    32'h0);

        // Fixed rotation 0->1->2->3->0 twice: green 20, yellow 8, all-red 4.
        do_reset();
        push(GR, 2'd0, 4);
        @(negedge clk); check("tick/cycle1", 32'(tick), 32'h0);
        @(negedge clk); check("tick/cycle2", 32'(tick), 32'h0);
        @(negedge clk); check("tick/cycle3", 32'(tick), 32'h1);
        @(negedge clk); check("tick/cycle4", 32'(tick), 32'h0);
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                push(YL, 2'(d), 20);
                push(AR, 2'(d), 8);
                push(GR, 2'((d + 1) % 4), 4);
            end
        end
        drain("rotate", 400);
        seg_end("rotate");

        // Demand skipping: extension with no demand, then jump to dir3,
        // then from dir3 search wraps past 0 and picks dir1 over dir2.
        skip_en = 1'b1;
        demand  = 4'b0000;
        do_reset();
        push(GR, 2'd0, 4);
        drain("skip_start", 50);
        repeat (50) @(negedge clk);
        check("extend/phase",   32'(phase),   32'(GR));
        check("extend/cur_dir", 32'(cur_dir), 32'h0);
        demand = 4'b1000;
        push(YL, 2'd0, 60);
        push(AR, 2'd0, 8);
        push(GR, 2'd3, 4);
        drain("skip_to3", 100);
        demand = 4'b0110;
        push(YL, 2'd3, 20);
        push(AR, 2'd3, 8);
        push(GR, 2'd1, 4);
        drain("skip_to1", 100);
        seg_end("skip");
        skip_en = 1'b0;
        demand  = 4'b0000;

        // Reset pulsed mid-yellow on dir2, then restart at dir0.
        do_reset();
        push(GR, 2'd0, 4);
        for (int d = 0; d < 2; d++) begin
            push(YL, 2'(d), 20);
            push(AR, 2'(d), 8);
            push(GR, 2'(d + 1), 4);
        end
        push(YL, 2'd2, 20);
        drain("to_yellow2", 200);
        repeat (3) @(negedge clk);
        check("pre_reset/phase",   32'(phase),   32'(YL));
        check("pre_reset/cur_dir", 32'(cur_dir), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset/lights",  32'(lights),  32'h0);
        check("async_reset/phase",   32'(phase),   32'(AR));
        check("async_reset/cur_dir", 32'(cur_dir), 32'h0);
        check("async_reset/tick",    32'(tick),    32'h0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        obs_rd = obs_wr;
        push(GR, 2'd0, 4);
        drain("restart", 50);
        seg_end("restart");

        // NUM_DIR=3 with zero green/yellow lengths: every phase is one tick.
        do_reset();
        for (int t = 1; t <= 44; t++) begin
            if (t < 4) begin
                e3.ph  = AR;
                e3.dir = 2'd0;
            end else begin
                seg    = (t - 4) / 4;
                e3.dir = 2'((seg / 3) % 3);
                e3.ph  = (seg % 3 == 0) ? GR : ((seg % 3 == 1) ? YL : AR);
            end
            e3.dur = 0;
            sb3.push_back(e3);
        end
        while (sb3.size() > 0) begin
            @(negedge clk);
            e3 = sb3.pop_front();
            check("n3/phase",   32'(phase3),   32'(e3.ph));
            check("n3/cur_dir", 32'(cur_dir3), 32'(e3.dir));
            check("n3/lights",  32'(lights3),  exp_l(e3.ph, e3.dir));
        end

`ifdef TL_PREEMPT_EN
        // Preempt to dir2 on the first tick of dir0 green; hold; release.
        do_reset();
        push(GR, 2'd0, 4);
        drain("pre_start", 50);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = tick;
        end
        check("pre/tick_seen", 32'(seen), 32'h1);
        #1 preempt_req = 1'b1;
        push(YL, 2'd0, 4);
        push(AR, 2'd0, 8);
        push(GR, 2'd2, 4);
        drain("pre_enter", 100);
        repeat (40) @(negedge clk);
        check("pre_hold/phase",   32'(phase),   32'(GR));
        check("pre_hold/cur_dir", 32'(cur_dir), 32'h2);
        #1 preempt_req = 1'b0;
        push(YL, 2'd2, 60);
        push(AR, 2'd2, 8);
        push(GR, 2'd3, 4);
        drain("pre_release", 150);
        seg_end("preempt");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_traffic_light_ctrl_n
